pi_2_unshuffle_buf: RTL and testbench



---
 rtl/pi_2_unshuffle_buf_if.sv | 27 ++
 rtl/pi_2_unshuffle_buf.sv | 86 ++++++++
 tb/tb_pi_2_unshuffle_buf.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pi_2_unshuffle_buf_if.sv
// Handshake bundle between the CNU array (beat side) and the PE array (frame side)
// for the inverse PE-to-CNU permutation buffer.
interface pi_2_unshuffle_buf_if #(
  parameter int DATA_WIDTH = 6
);

  logic                         in_valid;
  logic                         in_ready;
  logic                         in_first;
  logic [0:5][DATA_WIDTH-1:0]   in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [0:35][DATA_WIDTH-1:0]  out_data;
  logic                         frame_err;

  // Master drives beats and consumes frames; slave is the unshuffle buffer itself.
  modport master (
    output in_valid, in_first, in_data, out_ready,
    input  in_ready, out_valid, out_data, frame_err
  );

  modport slave (
    input  in_valid, in_first, in_data, out_ready,
    output in_ready, out_valid, out_data, frame_err
  );

endinterface

// File: rtl/pi_2_unshuffle_buf.sv
// Collects six CNU-group beats into a 36-word PE-ordered frame (group k lands in
// slots (5-k)*6..+5) using a ping-pong pair of frame banks.
module pi_2_unshuffle_buf #(
  parameter int DATA_WIDTH = 6
) (
  input logic                 clk,
  input logic                 rst_n,
  pi_2_unshuffle_buf_if.slave bus
);

  localparam int WORDS = 6;
  localparam int SLOTS = 36;

  logic [1:0][0:SLOTS-1][DATA_WIDTH-1:0] bank_q, bank_d;
  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [2:0] beat_cnt_q, beat_cnt_d;
  logic       frame_err_q, frame_err_d;

  logic       in_ready;
  logic       accept;
  logic       drain;
  logic [2:0] eff_k;
  logic [5:0] base;

  assign in_ready = !full_q[wr_sel_q];
  assign accept   = bus.in_valid && in_ready;
  assign drain    = full_q[rd_sel_q] && bus.out_ready;
  assign eff_k    = bus.in_first ? 3'd0 : beat_cnt_q;
  assign base     = 6'(3'd5 - eff_k) * 6'd6;

  // Completion and drain never hit the same bank: the write bank is by
  // construction never full, so both updates can apply in one cycle.
  always_comb begin
    bank_d      = bank_q;
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    beat_cnt_d  = beat_cnt_q;
    frame_err_d = 1'b0;

    if (accept) begin
      for (int j = 0; j < WORDS; j++) begin
        bank_d[wr_sel_q][base + 6'(j)] = bus.in_data[j];
      end
      frame_err_d = bus.in_first && (beat_cnt_q != 3'd0);
      if (eff_k == 3'd5) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        beat_cnt_d       = 3'd0;
      end else begin
        beat_cnt_d = eff_k + 3'd1;
      end
    end

    if (drain) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q      <= '0;
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      beat_cnt_q  <= 3'd0;
      frame_err_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = full_q[rd_sel_q];
  assign bus.out_data  = bank_q[rd_sel_q];
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_pi_2_unshuffle_buf.sv
// Directed bench for pi_2_unshuffle_buf: ordering, ping-pong backpressure,
// resync, simultaneous complete/drain, async reset and data-width extremes.
module tb_pi_2_unshuffle_buf;

  localparam int DW = 6;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pi_2_unshuffle_buf_if #(.DATA_WIDTH(DW)) bus ();

  pi_2_unshuffle_buf #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  // Beat k of a frame with the given base carries words base+6k+j.
  function automatic logic [0:5][DW-1:0] beatWords(input int b, input int k);
    logic [0:5][DW-1:0] w;
    for (int j = 0; j < 6; j++) w[j] = DW'(b + 6 * k + j);
    return w;
  endfunction

  // Slot s belongs to CNU group 5 - s/6, word s%6.
  function automatic logic [0:35][DW-1:0] expFrame(input int b);
    logic [0:35][DW-1:0] f;
    for (int s = 0; s < 36; s++) f[s] = DW'(b + 6 * (5 - s / 6) + (s % 6));
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [215:0] observed,
                             input logic [215:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Presents one beat and holds it until the edge on which it is accepted.
  task automatic applyStimulus(input logic first, input logic [0:5][DW-1:0] words);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.in_data  = words;
    while (!bus.in_ready && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput("beat_in_ready", 216'(bus.in_ready), 216'(1'b1));
    tick();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
  endtask

  task automatic sendFrame(input int b);
    for (int k = 0; k < 6; k++) applyStimulus(k == 0, beatWords(b, k));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #3;
    checkOutput("rst_out_valid", 216'(bus.out_valid), 216'(1'b0));
    checkOutput("rst_in_ready",  216'(bus.in_ready),  216'(1'b1));
    checkOutput("rst_frame_err", 216'(bus.frame_err), 216'(1'b0));
    checkOutput("rst_out_data",  bus.out_data, 216'(0));
    #19 rst_n = 1'b1;
    tick();

    $display("[TB] single ordered frame");
    bus.out_ready = 1'b1;
    sendFrame(0);
    checkOutput("single_valid",  216'(bus.out_valid), 216'(1'b1));
    checkOutput("single_slot0",  216'(bus.out_data[0]),  216'(30));
    checkOutput("single_slot35", 216'(bus.out_data[35]), 216'(5));
    checkOutput("single_frame",  bus.out_data, expFrame(0));
    tick();
    checkOutput("single_drained", 216'(bus.out_valid), 216'(1'b0));
    bus.out_ready = 1'b0;

    $display("[TB] ping-pong backpressure");
    sendFrame(10);
    sendFrame(20);
    checkOutput("pp_in_ready_low", 216'(bus.in_ready), 216'(1'b0));
    checkOutput("pp_frame1_held",  bus.out_data, expFrame(10));
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    bus.in_data  = beatWords(40, 0);
    tick();
    tick();
    checkOutput("pp_stall_ready", 216'(bus.in_ready), 216'(1'b0));
    checkOutput("pp_stall_hold",  bus.out_data, expFrame(10));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("pp_frame2_valid", 216'(bus.out_valid), 216'(1'b1));
    checkOutput("pp_frame2_data",  bus.out_data, expFrame(20));
    checkOutput("pp_ready_back",   216'(bus.in_ready), 216'(1'b1));
    for (int k = 0; k < 6; k++) applyStimulus(k == 0, beatWords(40, k));
    checkOutput("pp_full_again", 216'(bus.in_ready), 216'(1'b0));
    checkOutput("pp_frame2_kept", bus.out_data, expFrame(20));
    bus.out_ready = 1'b1;
    tick();
    checkOutput("pp_frame3_valid", 216'(bus.out_valid), 216'(1'b1));
    checkOutput("pp_frame3_data",  bus.out_data, expFrame(40));
    tick();
    checkOutput("pp_empty_valid", 216'(bus.out_valid), 216'(1'b0));
    checkOutput("pp_empty_ready", 216'(bus.in_ready),  216'(1'b1));
    bus.out_ready = 1'b0;

    $display("[TB] resync");
    for (int k = 0; k < 3; k++) applyStimulus(k == 0, beatWords(50, k));
    checkOutput("rs_no_err_yet", 216'(bus.frame_err), 216'(1'b0));
    applyStimulus(1'b1, beatWords(3, 0));
    checkOutput("rs_err_pulse", 216'(bus.frame_err), 216'(1'b1));
    applyStimulus(1'b0, beatWords(3, 1));
    checkOutput("rs_err_clear", 216'(bus.frame_err), 216'(1'b0));
    for (int k = 2; k < 5; k++) applyStimulus(1'b0, beatWords(3, k));
    checkOutput("rs_no_early_frame", 216'(bus.out_valid), 216'(1'b0));
    applyStimulus(1'b0, beatWords(3, 5));
    checkOutput("rs_valid", 216'(bus.out_valid), 216'(1'b1));
    checkOutput("rs_frame", bus.out_data, expFrame(3));
    bus.out_ready = 1'b1;
    tick();
    checkOutput("rs_single_frame", 216'(bus.out_valid), 216'(1'b0));
    bus.out_ready = 1'b0;

    $display("[TB] simultaneous complete and drain");
    sendFrame(5);
    for (int k = 0; k < 5; k++) applyStimulus(k == 0, beatWords(60, k));
    checkOutput("sim_first_held", bus.out_data, expFrame(5));
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, beatWords(60, 5));
    checkOutput("sim_valid", 216'(bus.out_valid), 216'(1'b1));
    checkOutput("sim_data",  bus.out_data, expFrame(60));
    checkOutput("sim_ready", 216'(bus.in_ready), 216'(1'b1));
    tick();
    checkOutput("sim_drained", 216'(bus.out_valid), 216'(1'b0));
    bus.out_ready = 1'b0;

    $display("[TB] reset mid-operation");
    sendFrame(21);
    for (int k = 0; k < 4; k++) applyStimulus(k == 0, beatWords(33, k));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mrst_out_valid", 216'(bus.out_valid), 216'(1'b0));
    checkOutput("mrst_out_data",  bus.out_data, 216'(0));
    checkOutput("mrst_in_ready",  216'(bus.in_ready), 216'(1'b1));
    tick();
    #3 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, beatWords(44, k));
    checkOutput("mrst_needs_six", 216'(bus.out_valid), 216'(1'b0));
    applyStimulus(1'b0, beatWords(44, 5));
    checkOutput("mrst_valid", 216'(bus.out_valid), 216'(1'b1));
    checkOutput("mrst_frame", bus.out_data, expFrame(44));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    $display("[TB] width extremes");
    for (int k = 0; k < 6; k++) applyStimulus(k == 0, {6{6'h3F}});
    checkOutput("ext_ones", bus.out_data, {216{1'b1}});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("ext_ones_drained", 216'(bus.out_valid), 216'(1'b0));
    for (int k = 0; k < 6; k++) applyStimulus(k == 0, {6{6'h00}});
    checkOutput("ext_zero_valid", 216'(bus.out_valid), 216'(1'b1));
    checkOutput("ext_zeros", bus.out_data, 216'(0));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
